// File: rtl/msx_mouse_if.sv
// MSX mouse adapter: host mouse reports -> MSX 4-nibble protocol, with per-port mouse/joystick switching.
// Define MSX_MOUSE_ACCUM_EN for saturating motion accumulation between reads; default is the legacy overwrite mode.
module msx_mouse_if #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 100000,
  parameter int SHIFT   = 1,
  parameter int ACC_W   = 12
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [8:0]           mouse_x,
  input  logic [8:0]           mouse_y,
  input  logic [7:0]           mouse_flags,
  input  logic                 mouse_strobe,
  input  logic                 mouse_port,
  input  logic [6*PORTS-1:0]   joy_in,
  input  logic [PORTS-1:0]     msx_str,
  output logic [6*PORTS-1:0]   port_out,
  output logic [PORTS-1:0]     mouse_active
);
  localparam int W  = ACC_W + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tmo;
  logic [3:0]       r_nib;
  logic [1:0]       r_btn;
  logic [7:0]       r_tx_x, r_tx_y;
  logic [PORTS-1:0] r_str_d;

  logic             w_mport;
  logic             w_edge;
  logic [3:0]       w_hi_x;
  logic signed [W-1:0] w_dx, w_dy;

  assign w_mport = (PORTS == 1) ? 1'b0 : mouse_port;
  assign w_edge  = mouse_active[w_mport] & (r_str_d[w_mport] ^ msx_str[w_mport]);

  // MSX counts X left-positive, so the host X delta is negated
  assign w_dx = (-W'(signed'(mouse_x))) >>> SHIFT;
  assign w_dy = W'(signed'(mouse_y)) >>> SHIFT;

`ifdef MSX_MOUSE_ACCUM_EN
  localparam logic signed [W-1:0] AMAX = W'((1 << (ACC_W - 1)) - 1);

  logic signed [ACC_W-1:0] r_acc_x, r_acc_y;
  logic                    w_snap;
  logic [7:0]              w_sx, w_sy;
  logic signed [W-1:0]     w_nx, w_ny;

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] a);
    if (a > 127)       return 8'h7F;
    else if (a < -128) return 8'h80;
    else               return a[7:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    if (v > AMAX)       r = AMAX;
    else if (v < -AMAX) r = -AMAX;
    else                r = v;
    return r[ACC_W-1:0];
  endfunction

  assign w_snap = w_edge && (r_state == S0);
  assign w_sx   = sat8(r_acc_x);
  assign w_sy   = sat8(r_acc_y);
  assign w_hi_x = w_sx[7:4];

  // Snapshot is taken from the pre-add value, so a coincident strobe is never lost
  always_comb begin
    w_nx = W'(r_acc_x);
    w_ny = W'(r_acc_y);
    if (mouse_strobe) begin
      w_nx = w_nx + w_dx;
      w_ny = w_ny + w_dy;
    end
    if (w_snap) begin
      w_nx = w_nx - W'(signed'(w_sx));
      w_ny = w_ny - W'(signed'(w_sy));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_tx_x  <= '0;
      r_tx_y  <= '0;
    end else begin
      r_acc_x <= sat_acc(w_nx);
      r_acc_y <= sat_acc(w_ny);
      if (w_snap) begin
        r_tx_x <= w_sx;
        r_tx_y <= w_sy;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{w_dx[W-1:8], w_dy[W-1:8]};
  assign w_hi_x   = r_tx_x[7:4];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_tx_x <= '0;
      r_tx_y <= '0;
    end else if (mouse_strobe) begin
      r_tx_x <= w_dx[7:0];
      r_tx_y <= w_dy[7:0];
    end else if (w_edge && r_state == S3) begin
      r_tx_x <= '0;
      r_tx_y <= '0;
    end
  end
`endif

  logic w_unused_flags;
  assign w_unused_flags = ^mouse_flags[7:2];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S0;
      r_tmo   <= '0;
      r_nib   <= '0;
      r_btn   <= 2'b11;
      r_str_d <= msx_str;
    end else begin
      r_str_d <= msx_str;
      r_btn   <= ~mouse_flags[1:0];
      if (!mouse_active[w_mport]) begin
        r_state <= S0;
        r_tmo   <= '0;
      end else if (w_edge) begin
        r_tmo <= TW'(TIMEOUT);
        case (r_state)
          S0: begin r_nib <= w_hi_x;      r_state <= S1; end
          S1: begin r_nib <= r_tx_x[3:0]; r_state <= S2; end
          S2: begin r_nib <= r_tx_y[7:4]; r_state <= S3; end
          S3: begin r_nib <= r_tx_y[3:0]; r_state <= S0; end
          default: r_state <= S0;
        endcase
      end else if (r_tmo == TW'(1)) begin
        r_state <= S0;
        r_tmo   <= '0;
      end else if (r_tmo != '0) begin
        r_tmo <= r_tmo - TW'(1);
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [5:0] w_joy;
    logic       w_sel;
    logic       r_act;
    logic [5:0] r_joyo;

    assign w_joy = joy_in[6*p +: 6];
    assign w_sel = (w_mport == 1'(p));

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_act  <= 1'b0;
        r_joyo <= 6'h3F;
      end else begin
        if (mouse_strobe && w_sel)            r_act <= 1'b1;
        else if (w_joy != 6'h3F || !w_sel)    r_act <= 1'b0;
        r_joyo <= msx_str[p] ? 6'h3F : w_joy;
      end
    end

    assign mouse_active[p]    = r_act;
    assign port_out[6*p +: 6] = r_act ? {r_btn, r_nib} : r_joyo;
  end
endmodule
